// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions: DMA sequencer states and fixed register addresses.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nes_bus_pkg;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_HALT,
        DMA_ALIGN,
        DMA_READ,
        DMA_WRITE
    } dma_state_t;

    localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
    localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

endpackage

// File: rtl/oam_dma_arbiter.sv
// Shares the CPU memory bus between the 6502 core and the sprite (OAM) DMA copy engine.
// Latency: IDLE bus is a combinational pass-through; a DMA stalls the core 2*XFER_LEN+1 (+1 ALIGN) cycles.
// Backpressure: cpu_rdy=0 freezes the core for the whole transfer; core accesses while busy are dropped.
// Build option OAM_DMA_ALIGN_EN: adds the ALIGN state so the first READ always lands on an even cycle.
module oam_dma_arbiter
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = ADDR_OAMDMA,
    parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAMDATA,
    parameter int          XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_we,
    output logic        cpu_rdy,
    input  logic [7:0]  mem_d_in,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_d_out,
    output logic        mem_we,
    output logic        dma_busy
);

    // Terminal byte index; XFER_LEN=256 ends at 8'hFF so idx never wraps.
    localparam logic [7:0] IDX_LAST = 8'(XFER_LEN - 1);

    dma_state_t state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] page_q, page_d;
    logic [7:0] latch_q, latch_d;
    logic       trigger;

    assign trigger = cpu_we && (cpu_addr == DMA_REG_ADDR);

`ifdef OAM_DMA_ALIGN_EN
    logic cyc_odd_q;

    // Free-running cycle parity, never touched by the DMA sequencer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_odd_q <= 1'b0;
        end else begin
            cyc_odd_q <= ~cyc_odd_q;
        end
    end
`endif

    // State register plus the transfer datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DMA_IDLE;
            idx_q   <= 8'h00;
            page_q  <= 8'h00;
            latch_q <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            page_q  <= page_d;
            latch_q <= latch_d;
        end
    end

    // Next-state and datapath update: launch on a register write, then alternate READ/WRITE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        page_d  = page_q;
        latch_d = latch_q;
        case (state_q)
            DMA_IDLE: begin
                if (trigger) begin
                    page_d  = cpu_d_out;
                    idx_d   = 8'h00;
                    state_d = DMA_HALT;
                end
            end
            DMA_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                // An even HALT cycle needs one filler cycle so READ lands on an even cycle.
                state_d = cyc_odd_q ? DMA_READ : DMA_ALIGN;
`else
                state_d = DMA_READ;
`endif
            end
            DMA_ALIGN: begin
                state_d = DMA_READ;
            end
            DMA_READ: begin
                latch_d = mem_d_in;
                state_d = DMA_WRITE;
            end
            DMA_WRITE: begin
                if (idx_q == IDX_LAST) begin
                    state_d = DMA_IDLE;
                end else begin
                    idx_d   = idx_q + 8'h01;
                    state_d = DMA_READ;
                end
            end
            default: begin
                state_d = DMA_IDLE;
            end
        endcase
    end

    // Bus mux and core stall: the core owns the bus only in IDLE.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_d_out = cpu_d_out;
        mem_we    = cpu_we;
        cpu_rdy   = 1'b1;
        dma_busy  = 1'b0;
        case (state_q)
            DMA_HALT, DMA_ALIGN: begin
                mem_we   = 1'b0;
                cpu_rdy  = 1'b0;
                dma_busy = 1'b1;
            end
            DMA_READ: begin
                mem_addr = {page_q, idx_q};
                mem_we   = 1'b0;
                cpu_rdy  = 1'b0;
                dma_busy = 1'b1;
            end
            DMA_WRITE: begin
                mem_addr  = OAM_DATA_ADDR;
                mem_d_out = latch_q;
                mem_we    = 1'b1;
                cpu_rdy   = 1'b0;
                dma_busy  = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Randomized scoreboard bench for oam_dma_arbiter against a memory-image model.
// Latency: expected bus cycles are queued at trigger time and popped per DMA cycle.
// Backpressure: core stimulus is noise while cpu_rdy is low; stall length is measured.
module tb_oam_dma_arbiter;

    localparam int L = 256;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_d_out;
    logic        cpu_we;
    logic        cpu_rdy;
    logic [7:0]  mem_d_in;
    logic [15:0] mem_addr;
    logic [7:0]  mem_d_out;
    logic        mem_we;
    logic        dma_busy;

    // kind 0 = HALT/ALIGN (bus shows core address), 1 = source read, 2 = OAM write
    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [7:0]  dat;
    } bus_ev_t;

    bus_ev_t     exp_q[$];
    logic [7:0]  rom [0:65535];
    int          n_chk;
    int          n_fail;
    int          oam_cnt;
    int          edges;

    oam_dma_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_d_out (cpu_d_out),
        .cpu_we    (cpu_we),
        .cpu_rdy   (cpu_rdy),
        .mem_d_in  (mem_d_in),
        .mem_addr  (mem_addr),
        .mem_d_out (mem_d_out),
        .mem_we    (mem_we),
        .dma_busy  (dma_busy)
    );

    assign mem_d_in = rom[mem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Clock edges since reset release: parity of the current cycle.
    always @(posedge clk or negedge rst) begin
        if (!rst) edges <= 0;
        else      edges <= edges + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every DMA cycle pops one expected bus event; idle cycles must pass through.
    always @(negedge clk) begin
        bus_ev_t ev;
        if (rst) begin
            if (dma_busy) begin
                if (mem_we && mem_addr == 16'h2004) oam_cnt++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL busy_extra: dma_busy=1 with no expected DMA cycle (t=%0t)", $time);
                end else begin
                    ev = exp_q.pop_front();
                    chk("busy_rdy", 32'(cpu_rdy), 32'd0);
                    chk("dma_we", 32'(mem_we), (ev.kind == 2) ? 32'd1 : 32'd0);
                    if (ev.kind == 0) chk("halt_addr", 32'(mem_addr), 32'(cpu_addr));
                    else              chk("dma_addr", 32'(mem_addr), 32'(ev.addr));
                    if (ev.kind == 2) chk("oam_data", 32'(mem_d_out), 32'(ev.dat));
                end
            end else begin
                chk("idle_rdy", 32'(cpu_rdy), 32'd1);
                chk("idle_addr", 32'(mem_addr), 32'(cpu_addr));
                chk("idle_dout", 32'(mem_d_out), 32'(cpu_d_out));
                chk("idle_we", 32'(mem_we), 32'(cpu_we));
            end
        end
    end

    task automatic idle_random(input int n);
        for (int c = 0; c < n; c++) begin
            cpu_addr  = 16'($urandom);
            if (cpu_addr == 16'h4014) cpu_addr = 16'h4015;
            cpu_d_out = 8'($urandom);
            cpu_we    = 1'($urandom);
            @(posedge clk); #1;
        end
        cpu_we = 1'b0;
    endtask

    // Called and returns at posedge+1. abort_at >= 0 asserts reset once that many bytes are written.
    task automatic run_dma(input logic [7:0] page, input bit halt_odd, input bit noise, input int abort_at);
        int      stall;
        int      exp_stall;
        bit      align;
        bus_ev_t ev;
        logic [7:0] b;
        cpu_we = 1'b0;
        if (((edges + 1) % 2) != (halt_odd ? 1 : 0)) begin
            @(posedge clk); #1;
        end
        align = 1'b0;
`ifdef OAM_DMA_ALIGN_EN
        align = !halt_odd;
`endif
        exp_stall = 2 * L + 1 + (align ? 1 : 0);
        ev = '{0, 16'h0000, 8'h00};
        exp_q.push_back(ev);
        if (align) exp_q.push_back(ev);
        for (int i = 0; i < L; i++) begin
            b = 8'(i);
            ev = '{1, {page, b}, 8'h00};
            exp_q.push_back(ev);
            ev = '{2, 16'h2004, rom[{page, b}]};
            exp_q.push_back(ev);
        end
        oam_cnt   = 0;
        cpu_addr  = 16'h4014;
        cpu_d_out = page;
        cpu_we    = 1'b1;
        @(posedge clk); #1;
        stall = 0;
        while (1) begin
            if (abort_at >= 0 && oam_cnt == abort_at) begin
                cpu_addr  = 16'h1234;
                cpu_d_out = 8'h5A;
                cpu_we    = 1'b1;
                #1 rst = 1'b0;
                #1;
                chk("rst_mid_rdy", 32'(cpu_rdy), 32'd1);
                chk("rst_mid_busy", 32'(dma_busy), 32'd0);
                chk("rst_mid_we", 32'(mem_we), 32'd1);
                chk("rst_mid_addr", 32'(mem_addr), 32'h1234);
                exp_q.delete();
                cpu_we = 1'b0;
                @(posedge clk);
                @(posedge clk); #1;
                rst = 1'b1;
                return;
            end
            if (noise && exp_q.size() > 0) begin
                case ($urandom % 3)
                    0:       cpu_addr = 16'h4014;
                    1:       cpu_addr = 16'h2004;
                    default: cpu_addr = 16'($urandom);
                endcase
                cpu_d_out = 8'($urandom);
                cpu_we    = 1'($urandom);
            end else begin
                cpu_we = 1'b0;
            end
            @(negedge clk);
            if (cpu_rdy) break;
            stall++;
            if (stall > 2000) begin
                n_chk++;
                n_fail++;
                $display("FAIL stall_timeout: cpu_rdy still low after %0d cycles", stall);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk("stall_len", 32'(stall), 32'(exp_stall));
        chk("oam_count", 32'(oam_cnt), 32'(L));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        oam_cnt = 0;
        for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) rom[16'h0300 + i] = 8'(i) ^ 8'hA5;

        rst       = 1'b1;
        cpu_addr  = 16'h4014;
        cpu_d_out = 8'h33;
        cpu_we    = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("reset_rdy", 32'(cpu_rdy), 32'd1);
        chk("reset_busy", 32'(dma_busy), 32'd0);
        chk("reset_we", 32'(mem_we), 32'd1);
        chk("reset_addr", 32'(mem_addr), 32'h4014);
        cpu_we = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;

        idle_random(150);
        run_dma(8'h02, 1'b1, 1'b0, -1);
        run_dma(8'h02, 1'b0, 1'b0, -1);
        run_dma(8'h03, 1'($urandom), 1'b1, -1);
        run_dma(8'h07, 1'b1, 1'b0, 5);
        run_dma(8'h07, 1'b0, 1'b1, -1);
        idle_random(50);
        for (int k = 0; k < 2; k++) begin
            run_dma(8'($urandom), 1'($urandom), 1'($urandom), -1);
        end
        idle_random(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
